// File: rtl/sb_downsize.sv
// sb_downsize: splits each 256-bit switchboard RX word into 256/OUT_WIDTH beats, LSB slice first.
// Optional statistics counters are enabled with `define SB_DOWNSIZE_STATS_EN.
module sb_downsize #(
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [255:0]         in_data,
    input  logic [31:0]          in_dest,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [31:0]          out_dest,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef SB_DOWNSIZE_STATS_EN
    ,
    output logic [31:0]          word_count,
    output logic [31:0]          pkt_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int BEATS = 256 / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (OUT_WIDTH != 8 && OUT_WIDTH != 16 && OUT_WIDTH != 32 &&
        OUT_WIDTH != 64 && OUT_WIDTH != 128 && OUT_WIDTH != 256) begin : g_bad_width
        $error("sb_downsize: OUT_WIDTH must be 8, 16, 32, 64, 128 or 256");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_beat;
    logic [255:0]         r_hold_data;
    logic [31:0]          r_hold_dest;
    logic                 r_hold_last;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [31:0]          r_out_dest;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic                 w_last_beat;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_next_beat;
    logic [8:0]           w_shift;
    logic [OUT_WIDTH-1:0] w_next_slice;

    assign w_last_beat  = (r_beat == CNT_W'(BEATS - 1));
    assign w_in_ready   = !rst && ((r_state == IDLE) ||
                                   (r_state == SEND && w_last_beat && out_ready));
    assign w_accept     = in_valid && w_in_ready;
    assign w_next_beat  = r_beat + 1'b1;
    // Shift instead of an indexed part-select keeps the index width-clean for every OUT_WIDTH.
    assign w_shift      = 9'(w_next_beat) * 9'(OUT_WIDTH);
    assign w_next_slice = OUT_WIDTH'(r_hold_data >> w_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_hold_data <= '0;
            r_hold_dest <= '0;
            r_hold_last <= 1'b0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_state     <= SEND;
            r_beat      <= '0;
            r_hold_data <= in_data;
            r_hold_dest <= in_dest;
            r_hold_last <= in_last;
            r_out_data  <= in_data[OUT_WIDTH-1:0];
            r_out_dest  <= in_dest;
            r_out_last  <= in_last && (BEATS == 1);
            r_out_valid <= 1'b1;
        end else if (r_state == SEND && out_ready) begin
            if (!w_last_beat) begin
                r_beat     <= w_next_beat;
                r_out_data <= w_next_slice;
                r_out_last <= r_hold_last && (w_next_beat == CNT_W'(BEATS - 1));
            end else begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_dest  = r_out_dest;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

`ifdef SB_DOWNSIZE_STATS_EN
    logic [31:0] r_word_count;
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count  <= '0;
            r_pkt_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept)
                r_word_count <= r_word_count + 32'd1;
            if (r_out_valid && r_out_last && out_ready)
                r_pkt_count <= r_pkt_count + 32'd1;
            if (r_out_valid && !out_ready && r_stall_count != '1)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign word_count  = r_word_count;
    assign pkt_count   = r_pkt_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_sb_downsize.sv
// Directed self-checking bench for sb_downsize at OUT_WIDTH 64, 32 and 256.
module tb_sb_downsize;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] in_data;
    logic [31:0]  in_dest;
    logic         in_last;
    logic         out_ready;
    logic         v64, v32, v256;

    logic         rdy64, ovld64, olst64;
    logic [63:0]  odat64;
    logic [31:0]  odst64;
    logic         rdy32, ovld32, olst32;
    logic [31:0]  odat32;
    logic [31:0]  odst32;
    logic         rdy256, ovld256, olst256;
    logic [255:0] odat256;
    logic [31:0]  odst256;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef SB_DOWNSIZE_STATS_EN
    logic [31:0] wc, pc, sc;
`endif

    sb_downsize #(.OUT_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(v64), .in_ready(rdy64), .out_data(odat64), .out_dest(odst64),
        .out_last(olst64), .out_valid(ovld64), .out_ready(out_ready)
`ifdef SB_DOWNSIZE_STATS_EN
        , .word_count(wc), .pkt_count(pc), .stall_count(sc)
`endif
    );

    sb_downsize #(.OUT_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(v32), .in_ready(rdy32), .out_data(odat32), .out_dest(odst32),
        .out_last(olst32), .out_valid(ovld32), .out_ready(out_ready)
`ifdef SB_DOWNSIZE_STATS_EN
        , .word_count(), .pkt_count(), .stall_count()
`endif
    );

    sb_downsize #(.OUT_WIDTH(256)) u256 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(v256), .in_ready(rdy256), .out_data(odat256), .out_dest(odst256),
        .out_last(olst256), .out_valid(ovld256), .out_ready(out_ready)
`ifdef SB_DOWNSIZE_STATS_EN
        , .word_count(), .pkt_count(), .stall_count()
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] word64(input int unsigned base);
        logic [255:0] w;
        for (int unsigned l = 0; l < 4; l++)
            w[l*64 +: 64] = 64'(base + l);
        return w;
    endfunction

    function automatic logic [255:0] word32(input int unsigned base);
        logic [255:0] w;
        for (int unsigned l = 0; l < 8; l++)
            w[l*32 +: 32] = 32'(base + l);
        return w;
    endfunction

    initial begin
        logic [4:0] lasts;
        rst = 1'b1; in_data = '0; in_dest = '0; in_last = 1'b0;
        out_ready = 1'b0; v64 = 1'b0; v32 = 1'b0; v256 = 1'b0;

        // Reset state
        #1;
        chk("rst_in_ready", rdy64, 1'b0);
        chk("rst_out_valid", ovld64, 1'b0);
        chk("rst_out_data", odat64, 64'd0);
        chk("rst_out_last", olst64, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", rdy64, 1'b1);

        // Single word, four 64-bit beats
        in_data = {64'd4, 64'd3, 64'd2, 64'd1};
        in_dest = 32'h12; in_last = 1'b1; v64 = 1'b1; out_ready = 1'b1;
        step();
        v64 = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            chk("t1_valid", ovld64, 1'b1);
            chk("t1_data", odat64, 64'(k));
            chk("t1_dest", odst64, 32'h12);
            chk("t1_last", olst64, k == 4);
            step();
        end
        chk("t1_idle_valid", ovld64, 1'b0);
        chk("t1_idle_last", olst64, 1'b0);

        // Three back-to-back words, no bubbles
        in_data = word64(32'hA0); in_dest = 32'h20; in_last = 1'b1; v64 = 1'b1;
        chk("t2_ready_c0", rdy64, 1'b1);
        step();
        for (int unsigned b = 0; b < 12; b++) begin
            chk("t2_valid", ovld64, 1'b1);
            chk("t2_data", odat64, 64'(32'hA0 + (b / 4) * 16 + (b % 4)));
            chk("t2_last", olst64, (b % 4) == 3);
            chk("t2_in_ready", rdy64, (b % 4) == 3);
            if (b % 4 == 0) begin
                if (b / 4 < 2) in_data = word64(32'hA0 + (b / 4 + 1) * 16);
                else v64 = 1'b0;
            end
            step();
        end
        chk("t2_idle_valid", ovld64, 1'b0);
        in_data = '0;

        // 32-bit beats with out_ready alternating
        in_data = word32(32'hC0); in_dest = 32'h34; in_last = 1'b1; v32 = 1'b1;
        step();
        v32 = 1'b0; in_data = '0;
        for (int unsigned c = 0; c < 16; c++) begin
            out_ready = c[0];
            chk("t3_valid", ovld32, 1'b1);
            chk("t3_data", odat32, 32'(32'hC0 + c / 2));
            chk("t3_dest", odst32, 32'h34);
            chk("t3_last", olst32, (c / 2) == 7);
            step();
        end
        chk("t3_idle_valid", ovld32, 1'b0);

        // Reset in the middle of a word
        out_ready = 1'b1;
        in_data = word64(32'hD0); in_dest = 32'h56; in_last = 1'b1; v64 = 1'b1;
        step();
        v64 = 1'b0;
        step();
        step();
        chk("t4_beat2_data", odat64, 64'hD2);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", ovld64, 1'b0);
        chk("t4_rst_data", odat64, 64'd0);
        chk("t4_rst_dest", odst64, 32'd0);
        chk("t4_rst_in_ready", rdy64, 1'b0);
        step();
        chk("t4_rst_hold_valid", ovld64, 1'b0);
        rst = 1'b0;
        #1;
        chk("t4_release_in_ready", rdy64, 1'b1);
        in_data = word64(32'hE0); in_dest = 32'h78; in_last = 1'b0; v64 = 1'b1;
        step();
        v64 = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            chk("t4_new_data", odat64, 64'(32'hE0 + k));
            chk("t4_new_last", olst64, 1'b0);
            step();
        end
        chk("t4_idle_valid", ovld64, 1'b0);

        // OUT_WIDTH=256: one output per cycle, zero-bubble refill
        lasts = 5'b10100;
        in_data = {8{32'h1000_0000}}; in_dest = 32'h9A; in_last = lasts[0]; v256 = 1'b1;
        chk("t5_ready_idle", rdy256, 1'b1);
        step();
        for (int unsigned j = 0; j < 5; j++) begin
            chk("t5_valid", ovld256, 1'b1);
            chk("t5_data", odat256, {8{32'(32'h1000_0000 + j)}});
            chk("t5_last", olst256, lasts[j]);
            chk("t5_in_ready", rdy256, 1'b1);
            if (j < 4) begin
                in_data = {8{32'(32'h1000_0000 + j + 1)}};
                in_last = lasts[j + 1];
            end else begin
                v256 = 1'b0;
            end
            step();
        end
        chk("t5_idle_valid", ovld256, 1'b0);

`ifdef SB_DOWNSIZE_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_wc_rst", wc, 32'd0);
        chk("t6_pc_rst", pc, 32'd0);
        chk("t6_sc_rst", sc, 32'd0);
        in_data = word64(32'hF0); in_dest = 32'h1; in_last = 1'b1; v64 = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step(); step(); step();
        out_ready = 1'b1;
        step(); step(); step(); step();
        v64 = 1'b0;
        step(); step(); step(); step();
        chk("t6_idle_valid", ovld64, 1'b0);
        chk("t6_word_count", wc, 32'd2);
        chk("t6_pkt_count", pc, 32'd2);
        chk("t6_stall_count", sc, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_downsize.md
Name: sb_downsize

Overview:
- Synthesizable consumer of the 256-bit switchboard receive stream (data/dest/last with valid/ready).
- Captures one 256-bit word and re-emits it as 256/OUT_WIDTH narrower beats, LSB slice first.
- Sits between the switchboard RX endpoint and narrow DUT-side logic.
- Provides full back-pressure on both sides; zero-bubble word-to-word throughput.

Parameters:
- OUT_WIDTH, 64: output beat width in bits. Legal values are 8, 16, 32, 64, 128 and 256. Any other value triggers an elaboration-time $error.
- BEATS, 256/OUT_WIDTH: derived localparam, not overridable. Number of beats per input word.
- CNT_W, $clog2(BEATS) with a minimum of 1: derived localparam. Width of the beat counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  256  input word.
- in_dest  input  32  input destination.
- in_last  input  1  end-of-packet flag of the input word.
- in_valid  input  1  input word is valid.
- in_ready  output  1  block accepts the input word this cycle.
- out_data  output  OUT_WIDTH  current beat.
- out_dest  output  32  destination of the held word, repeated on every beat.
- out_last  output  1  end-of-packet flag on the final beat.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset: while rst is high, asynchronously force:
  - state=IDLE, beat=0
  - hold_data=0, hold_dest=0, hold_last=0
  - out_valid=0, out_last=0, out_data=0, out_dest=0
  - in_ready=0 while rst is asserted; it rises combinationally once rst deasserts.
- State machine (2 states):
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid: load hold_* from in_*, set beat=0, go to SEND.
  - SEND: out_valid=1.
    - out_data = hold_data[beat*OUT_WIDTH +: OUT_WIDTH].
    - out_dest = hold_dest.
    - out_last = hold_last && (beat==BEATS-1).
    - On out_ready with beat<BEATS-1: beat increments.
    - On out_ready with beat==BEATS-1:
      - if in_valid: load the new word, set beat=0, stay in SEND (no bubble).
      - otherwise: go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && beat==BEATS-1 && out_ready). This is combinational from out_ready; no combinational path from in_valid to any output.
- Latency: the first beat appears 1 cycle after input acceptance.
- Throughput: 1 beat per cycle sustained while out_ready=1. An input word is accepted every BEATS cycles.
- Back-pressure:
  - While out_ready=0, out_data, out_dest, out_last and beat hold stable.
  - out_valid never drops without a handshake.
- Input stability: in_* are sampled only on the in_valid && in_ready cycle.
- in_last=0 words: no out_last on any beat. Packet boundaries pass through unchanged; there is no repacking across words.
- OUT_WIDTH=256: BEATS=1, and the block behaves as a single-entry pipeline register with zero-bubble refill.
- Reset during SEND: the held word is discarded and no remaining beats are emitted. After reset the block is in IDLE with an empty hold register.
- Simultaneous final-beat handshake and new in_valid: both complete in the same cycle, per the SEND rule above.

Optional Feature:
- Macro: SB_DOWNSIZE_STATS_EN.
- With the macro defined, the block adds three ports, all reset to 0 by rst:
  - word_count  output  32: increments on each input handshake; wraps 0xFFFFFFFF to 0.
  - pkt_count  output  32: increments on each output beat with out_last && out_ready; wraps 0xFFFFFFFF to 0.
  - stall_count  output  32: increments each cycle out_valid && !out_ready; saturates at 0xFFFFFFFF.
- Without the macro, these ports and their registers do not exist, and datapath behaviour is identical in both builds.

Test Plan:
- OUT_WIDTH=64, out_ready=1, one word data=0x0004..0003..0002..0001 (64-bit lanes 1,2,3,4 from the LSB), dest=0x12, last=1 -> out_data 1,2,3,4 on 4 consecutive cycles starting 1 cycle after accept; out_dest=0x12 on all beats; out_last only on beat 4; then IDLE with out_valid=0.
- OUT_WIDTH=64, in_valid held high with 3 words, out_ready=1 -> 12 beats with no gaps; in_ready high only in the accept cycles (cycles 0, 4, 8 relative to the first accept).
- OUT_WIDTH=32, out_ready toggling 1,0,1,0 -> each beat held stable through the low cycles; 8 beats emitted in order; out_valid never deasserts mid-word.
- OUT_WIDTH=64, assert rst after beat 2 of a word -> all outputs go to 0 immediately; after release, a new word emits from beat 0 with no stale beats.
- OUT_WIDTH=256, continuous stream of 5 words with last=0,0,1,0,1 -> 5 outputs, one per cycle; out_last set on the 3rd and 5th.
- SB_DOWNSIZE_STATS_EN, OUT_WIDTH=64, 2 words (last=1 each) with 3 stall cycles -> word_count=2, pkt_count=2, stall_count=3.
